// File: rtl/ft232h_rx.sv
// FT232H synchronous-FIFO receive engine: drives OE#/RD#, captures bytes into a small skid
// buffer and presents them on an AXI-Stream source with a running delivered-byte counter.
module ft232h_rx #(
  parameter int SKID_DEPTH = 4
) (
  input  logic        ftdi_clk,
  input  logic        rst,
  input  logic        ftdi_rxf_n,
  input  logic [7:0]  ftdi_adbus,
  output logic        ftdi_oe_n,
  output logic        ftdi_rd_n,
  output logic [7:0]  host_axis_tdata,
  output logic        host_axis_tvalid,
  input  logic        host_axis_tready,
  output logic [31:0] rx_byte_count
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(SKID_DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    TURNAROUND,
    READ
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             oe_n_d;
  logic             rd_n_d;

  logic [7:0]       mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  // A byte is on the bus whenever the registered strobe and the device flag are both low.
  assign push       = !ftdi_rd_n && !ftdi_rxf_n;
  assign pop        = host_axis_tvalid && host_axis_tready;
  assign count_next = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

  assign host_axis_tvalid = (count != '0);
  assign host_axis_tdata  = mem[rd_ptr];

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ftdi_oe_n <= 1'b1;
      ftdi_rd_n <= 1'b1;
    end else begin
      state_q   <= state_d;
      ftdi_oe_n <= oe_n_d;
      ftdi_rd_n <= rd_n_d;
    end
  end

  // Strobe levels are decided here and registered above, so the pins never follow an input combinationally.
  always_comb begin
    state_d = state_q;
    oe_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (!ftdi_rxf_n && (count <= FILL_LIMIT)) begin
          state_d = TURNAROUND;
          oe_n_d  = 1'b0;
        end
      end
      TURNAROUND: begin
        if (!ftdi_rxf_n) begin
          state_d = READ;
          oe_n_d  = 1'b0;
          rd_n_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (!ftdi_rxf_n && (count_next <= FILL_LIMIT)) begin
          oe_n_d = 1'b0;
          rd_n_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ftdi_adbus;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      rx_byte_count <= '0;
    end else if (pop) begin
      rx_byte_count <= rx_byte_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ft232h_rx.sv
// Directed bench for ft232h_rx: a small FT232H byte-source model feeds the bus and a
// per-cycle monitor records delivered bytes, buffer occupancy and strobe ordering.
module tb_ft232h_rx;

  localparam int DEPTH = 4;

  logic        ftdi_clk = 1'b0;
  logic        rst;
  logic        ftdi_rxf_n;
  logic [7:0]  ftdi_adbus;
  logic        ftdi_oe_n;
  logic        ftdi_rd_n;
  logic [7:0]  host_axis_tdata;
  logic        host_axis_tvalid;
  logic        host_axis_tready;
  logic [31:0] rx_byte_count;

  int          checks_total  = 0;
  int          checks_passed = 0;

  logic [7:0]  dev_q[$];
  logic [7:0]  out_q[$];
  bit          model_en   = 1'b0;
  bit          ready_rand = 1'b0;
  int          occ        = 0;
  int          max_occ    = 0;
  int          viol       = 0;
  int          cyc        = 0;
  int          cap_total  = 0;
  int          oe_fall_cyc = 0;
  int          rd_fall_cyc = 0;
  logic        prev_oe_n  = 1'b1;
  logic        prev_rd_n  = 1'b1;

  ft232h_rx #(.SKID_DEPTH(DEPTH)) dut (
    .ftdi_clk         (ftdi_clk),
    .rst              (rst),
    .ftdi_rxf_n       (ftdi_rxf_n),
    .ftdi_adbus       (ftdi_adbus),
    .ftdi_oe_n        (ftdi_oe_n),
    .ftdi_rd_n        (ftdi_rd_n),
    .host_axis_tdata  (host_axis_tdata),
    .host_axis_tvalid (host_axis_tvalid),
    .host_axis_tready (host_axis_tready),
    .rx_byte_count    (rx_byte_count)
  );

  always #8 ftdi_clk = ~ftdi_clk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One clock: observe at the falling edge, then update the device model and inputs just after the rising edge.
  task automatic tick();
    logic bus_pop;
    logic cap;
    logic hs;
    @(negedge ftdi_clk);
    bus_pop = (ftdi_rd_n === 1'b0) && (ftdi_rxf_n === 1'b0);
    cap     = bus_pop && (rst === 1'b0);
    hs      = (host_axis_tvalid === 1'b1) && (host_axis_tready === 1'b1) && (rst === 1'b0);
    if (hs) out_q.push_back(host_axis_tdata);
    if (ftdi_rd_n === 1'b0 && ftdi_oe_n !== 1'b0) viol++;
    if (prev_rd_n === 1'b1 && ftdi_rd_n === 1'b0 && prev_oe_n !== 1'b0) viol++;
    if (prev_oe_n === 1'b1 && ftdi_oe_n === 1'b0) oe_fall_cyc = cyc;
    if (prev_rd_n === 1'b1 && ftdi_rd_n === 1'b0) rd_fall_cyc = cyc;
    prev_oe_n = ftdi_oe_n;
    prev_rd_n = ftdi_rd_n;
    if (cap && occ >= DEPTH) viol++;
    if (rst === 1'b1) begin
      occ = 0;
    end else begin
      if (cap) occ++;
      if (hs) occ--;
    end
    if (occ > max_occ) max_occ = occ;
    if (cap) cap_total++;
    @(posedge ftdi_clk);
    #1;
    cyc++;
    if (bus_pop && dev_q.size() > 0) void'(dev_q.pop_front());
    if (model_en) begin
      ftdi_rxf_n = (dev_q.size() == 0);
      ftdi_adbus = (dev_q.size() > 0) ? dev_q[0] : 8'h00;
    end
    if (ready_rand) host_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_source();
    ftdi_rxf_n = (dev_q.size() == 0);
    ftdi_adbus = (dev_q.size() > 0) ? dev_q[0] : 8'h00;
    model_en   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ftdi_rxf_n = 1'b0;
    repeat (3) tick();
    checks_total++;
    if (ftdi_oe_n !== 1'b1) $display("[TB] FAIL reset_oe_n: got %b expected 1", ftdi_oe_n);
    else checks_passed++;
    checks_total++;
    if (ftdi_rd_n !== 1'b1) $display("[TB] FAIL reset_rd_n: got %b expected 1", ftdi_rd_n);
    else checks_passed++;
    checks_total++;
    if (host_axis_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b expected 0", host_axis_tvalid);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd0) $display("[TB] FAIL reset_count: got %h expected 00000000", rx_byte_count);
    else checks_passed++;
    rst = 1'b0;
    tick();
    checks_total++;
    if (ftdi_oe_n !== 1'b0) $display("[TB] FAIL post_reset_turnaround_oe_n: got %b expected 0", ftdi_oe_n);
    else checks_passed++;
    checks_total++;
    if (ftdi_rd_n !== 1'b1) $display("[TB] FAIL post_reset_turnaround_rd_n: got %b expected 1", ftdi_rd_n);
    else checks_passed++;
    ftdi_rxf_n = 1'b1;
    tick();
    checks_total++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1)
      $display("[TB] FAIL post_reset_back_to_idle: got oe_n=%b rd_n=%b expected 1/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    repeat (2) tick();
  endtask

  task automatic test_basic_burst();
    logic [7:0] exp_b [3];
    int n;
    exp_b = '{8'h11, 8'h22, 8'h33};
    out_q.delete();
    viol = 0;
    host_axis_tready = 1'b1;
    dev_q = '{8'h11, 8'h22, 8'h33};
    start_source();
    n = 0;
    while (out_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks_total++;
    if (out_q.size() != 3) $display("[TB] FAIL burst_size: got %0d expected 3", out_q.size());
    else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      checks_total++;
      if (out_q.size() <= i) $display("[TB] FAIL burst_byte%0d: got none expected %h", i, exp_b[i]);
      else if (out_q[i] !== exp_b[i]) $display("[TB] FAIL burst_byte%0d: got %h expected %h", i, out_q[i], exp_b[i]);
      else checks_passed++;
    end
    checks_total++;
    if (rx_byte_count !== 32'd3) $display("[TB] FAIL burst_count: got %h expected 00000003", rx_byte_count);
    else checks_passed++;
    checks_total++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1)
      $display("[TB] FAIL burst_strobes_idle: got oe_n=%b rd_n=%b expected 1/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    checks_total++;
    if (rd_fall_cyc - oe_fall_cyc != 1)
      $display("[TB] FAIL burst_oe_lead: got %0d cycles expected 1", rd_fall_cyc - oe_fall_cyc);
    else checks_passed++;
    checks_total++;
    if (viol != 0) $display("[TB] FAIL burst_protocol: got %0d violations expected 0", viol);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    int n;
    out_q.delete();
    viol = 0;
    max_occ = 0;
    host_axis_tready = 1'b0;
    dev_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    start_source();
    repeat (20) tick();
    checks_total++;
    if (occ != 3) $display("[TB] FAIL bp_occupancy: got %0d expected 3", occ);
    else checks_passed++;
    checks_total++;
    if (ftdi_rd_n !== 1'b1 || ftdi_oe_n !== 1'b1)
      $display("[TB] FAIL bp_strobes_stopped: got oe_n=%b rd_n=%b expected 1/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    checks_total++;
    if (dev_q.size() != 3) $display("[TB] FAIL bp_device_left: got %0d expected 3", dev_q.size());
    else checks_passed++;
    checks_total++;
    if (host_axis_tvalid !== 1'b1 || host_axis_tdata !== 8'h41)
      $display("[TB] FAIL bp_hold_head: got valid=%b data=%h expected 1/41", host_axis_tvalid, host_axis_tdata);
    else checks_passed++;
    host_axis_tready = 1'b1;
    n = 0;
    while (out_q.size() < 6 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks_total++;
    if (out_q.size() != 6) $display("[TB] FAIL bp_drain_size: got %0d expected 6", out_q.size());
    else checks_passed++;
    for (int i = 0; i < 6; i++) begin
      checks_total++;
      if (out_q.size() <= i) $display("[TB] FAIL bp_byte%0d: got none expected %h", i, 8'(8'h41 + i));
      else if (out_q[i] !== 8'(8'h41 + i)) $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, out_q[i], 8'(8'h41 + i));
      else checks_passed++;
    end
    checks_total++;
    if (max_occ > DEPTH) $display("[TB] FAIL bp_max_occupancy: got %0d expected <= %0d", max_occ, DEPTH);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd9) $display("[TB] FAIL bp_count: got %h expected 00000009", rx_byte_count);
    else checks_passed++;
    checks_total++;
    if (viol != 0) $display("[TB] FAIL bp_protocol: got %0d violations expected 0", viol);
    else checks_passed++;
  endtask

  task automatic test_turnaround_glitch();
    int caps0;
    model_en = 1'b0;
    ftdi_rxf_n = 1'b1;
    repeat (3) tick();
    caps0 = cap_total;
    out_q.delete();
    ftdi_rxf_n = 1'b0;
    tick();
    ftdi_rxf_n = 1'b1;
    checks_total++;
    if (ftdi_oe_n !== 1'b0 || ftdi_rd_n !== 1'b1)
      $display("[TB] FAIL glitch_turnaround: got oe_n=%b rd_n=%b expected 0/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    tick();
    checks_total++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1)
      $display("[TB] FAIL glitch_back_idle: got oe_n=%b rd_n=%b expected 1/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    repeat (4) tick();
    checks_total++;
    if (host_axis_tvalid !== 1'b0) $display("[TB] FAIL glitch_tvalid: got %b expected 0", host_axis_tvalid);
    else checks_passed++;
    checks_total++;
    if (cap_total != caps0) $display("[TB] FAIL glitch_no_capture: got %0d captures expected 0", cap_total - caps0);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd9) $display("[TB] FAIL glitch_count: got %h expected 00000009", rx_byte_count);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int n;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks_total++;
    if (rx_byte_count !== 32'd0) $display("[TB] FAIL b2b_reset_count: got %h expected 00000000", rx_byte_count);
    else checks_passed++;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'($urandom));
    dev_q = exp_q;
    out_q.delete();
    viol = 0;
    max_occ = 0;
    ready_rand = 1'b1;
    start_source();
    n = 0;
    while (out_q.size() < 256 && n < 5000) begin
      tick();
      n++;
    end
    ready_rand = 1'b0;
    host_axis_tready = 1'b1;
    repeat (3) tick();
    checks_total++;
    if (out_q.size() != 256) $display("[TB] FAIL b2b_size: got %0d expected 256", out_q.size());
    else checks_passed++;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (out_q.size() <= i || out_q[i] !== exp_q[i]) bad++;
    end
    checks_total++;
    if (bad != 0) $display("[TB] FAIL b2b_order: got %0d wrong bytes expected 0", bad);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd256) $display("[TB] FAIL b2b_count: got %h expected 00000100", rx_byte_count);
    else checks_passed++;
    checks_total++;
    if (max_occ > DEPTH) $display("[TB] FAIL b2b_max_occupancy: got %0d expected <= %0d", max_occ, DEPTH);
    else checks_passed++;
    checks_total++;
    if (viol != 0) $display("[TB] FAIL b2b_protocol: got %0d violations expected 0", viol);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_read();
    int n;
    host_axis_tready = 1'b0;
    out_q.delete();
    dev_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    start_source();
    n = 0;
    while (occ < 2 && n < 50) begin
      tick();
      n++;
    end
    checks_total++;
    if (occ != 2 || ftdi_rd_n !== 1'b0)
      $display("[TB] FAIL rmr_in_read: got occ=%0d rd_n=%b expected 2/0", occ, ftdi_rd_n);
    else checks_passed++;
    rst = 1'b1;
    tick();
    checks_total++;
    if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1)
      $display("[TB] FAIL rmr_strobes: got oe_n=%b rd_n=%b expected 1/1", ftdi_oe_n, ftdi_rd_n);
    else checks_passed++;
    checks_total++;
    if (host_axis_tvalid !== 1'b0) $display("[TB] FAIL rmr_tvalid: got %b expected 0", host_axis_tvalid);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd0) $display("[TB] FAIL rmr_count: got %h expected 00000000", rx_byte_count);
    else checks_passed++;
    model_en = 1'b0;
    dev_q.delete();
    ftdi_rxf_n = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    out_q.delete();
    host_axis_tready = 1'b1;
    dev_q = '{8'hA5};
    start_source();
    n = 0;
    while (out_q.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks_total++;
    if (out_q.size() != 1) $display("[TB] FAIL rmr_next_size: got %0d expected 1", out_q.size());
    else checks_passed++;
    checks_total++;
    if (out_q.size() < 1) $display("[TB] FAIL rmr_next_byte: got none expected a5");
    else if (out_q[0] !== 8'hA5) $display("[TB] FAIL rmr_next_byte: got %h expected a5", out_q[0]);
    else checks_passed++;
    checks_total++;
    if (rx_byte_count !== 32'd1) $display("[TB] FAIL rmr_next_count: got %h expected 00000001", rx_byte_count);
    else checks_passed++;
  endtask

  task automatic test_count_wrap();
    int n;
    host_axis_tready = 1'b0;
    out_q.delete();
    force dut.rx_byte_count = 32'hFFFFFFFF;
    tick();
    release dut.rx_byte_count;
    tick();
    checks_total++;
    if (rx_byte_count !== 32'hFFFFFFFF) $display("[TB] FAIL wrap_preload: got %h expected ffffffff", rx_byte_count);
    else checks_passed++;
    dev_q = '{8'h5A, 8'h5B};
    start_source();
    n = 0;
    while (occ < 2 && n < 50) begin
      tick();
      n++;
    end
    checks_total++;
    if (host_axis_tvalid !== 1'b1 || host_axis_tdata !== 8'h5A)
      $display("[TB] FAIL wrap_head: got valid=%b data=%h expected 1/5a", host_axis_tvalid, host_axis_tdata);
    else checks_passed++;
    host_axis_tready = 1'b1;
    tick();
    checks_total++;
    if (rx_byte_count !== 32'h00000000) $display("[TB] FAIL wrap_first_pop: got %h expected 00000000", rx_byte_count);
    else checks_passed++;
    checks_total++;
    if (host_axis_tdata !== 8'h5B) $display("[TB] FAIL wrap_second_head: got %h expected 5b", host_axis_tdata);
    else checks_passed++;
    tick();
    checks_total++;
    if (rx_byte_count !== 32'h00000001) $display("[TB] FAIL wrap_second_pop: got %h expected 00000001", rx_byte_count);
    else checks_passed++;
    checks_total++;
    if (out_q.size() != 2 || out_q[0] !== 8'h5A || out_q[1] !== 8'h5B)
      $display("[TB] FAIL wrap_bytes: got %0d bytes expected 2 (5a,5b)", out_q.size());
    else checks_passed++;
  endtask

  initial begin
    rst              = 1'b1;
    ftdi_rxf_n       = 1'b1;
    ftdi_adbus       = 8'h00;
    host_axis_tready = 1'b0;
    $display("[TB] ft232h_rx bench start");
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_turnaround_glitch();
    test_back_to_back();
    test_reset_mid_read();
    test_count_wrap();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ft232h_rx.md
FT232H_RX -- requirements
Module: ft232h_rx

Interface
REQ-001 Parameter SKID_DEPTH, default 4, depth of the internal byte buffer; power of two, minimum 4.
REQ-002 ftdi_clk  input  1  60 MHz clock from FT232H; the only clock in the block.
REQ-003 rst  input  1  reset, synchronous to ftdi_clk, active-high.
REQ-004 ftdi_rxf_n  input  1  FT232H "receive data available", active-low.
REQ-005 ftdi_adbus  input  8  FT232H data bus, driven by the device while ftdi_oe_n is low.
REQ-006 ftdi_oe_n  output  1  bus output-enable request to FT232H, active-low.
REQ-007 ftdi_rd_n  output  1  read strobe to FT232H, active-low.
REQ-008 host_axis_tdata  output  8  received byte, AXI-Stream source.
REQ-009 host_axis_tvalid  output  1  AXI-Stream valid.
REQ-010 host_axis_tready  input  1  AXI-Stream ready from the consumer.
REQ-011 rx_byte_count  output  32  total bytes delivered on host_axis, wraps modulo 2^32.

Function
REQ-012 The block SHALL register ftdi_oe_n and ftdi_rd_n; neither output has a combinational path from any input.
REQ-013 The block SHALL implement states IDLE, TURNAROUND and READ.
REQ-014 IDLE: oe_n=1, rd_n=1; move to TURNAROUND when rxf_n==0 and buffer count <= SKID_DEPTH-2.
REQ-015 TURNAROUND: oe_n=0, rd_n=1 for exactly one cycle.
REQ-016 From TURNAROUND, the block SHALL go to READ (rd_n=0) if rxf_n==0; otherwise it SHALL return to IDLE (oe_n=1).
REQ-017 A byte SHALL be captured into the buffer at each rising edge where the registered rd_n is 0 and ftdi_rxf_n is 0.
REQ-018 No byte SHALL be captured at any other edge.
REQ-019 READ: rd_n and oe_n SHALL stay 0 for the next cycle only if rxf_n==0 and next buffer count <= SKID_DEPTH-2.
REQ-020 Otherwise the block SHALL drive rd_n=1 and oe_n=1 on the same edge and go to IDLE.
REQ-021 "Next buffer count" SHALL include the capture and any pop occurring at the same edge.
REQ-022 A capture SHALL never occur while the buffer is full; no overflow path exists.
REQ-023 Buffer: FIFO of SKID_DEPTH bytes.
REQ-024 host_axis_tvalid SHALL equal (count != 0); host_axis_tdata SHALL be the oldest byte.
REQ-025 Pop SHALL occur on tvalid && tready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve byte order.
REQ-027 Push into an empty buffer SHALL raise tvalid in the cycle after the capture edge (1-cycle latency); there is no bypass path.
REQ-028 tdata SHALL remain stable while tvalid=1 and tready=0.
REQ-029 Read and write pointers SHALL wrap modulo SKID_DEPTH; count SHALL be $clog2(SKID_DEPTH)+1 bits wide.
REQ-030 rx_byte_count SHALL increment by 1 on every pop, wrapping from 0xFFFFFFFF to 0.
REQ-031 rxf_n rising mid-burst SHALL stop captures immediately; the block SHALL return to IDLE with both strobes high on that edge.
REQ-032 tready low for any length SHALL cause no lost, duplicated or reordered bytes.

Reset
REQ-033 While rst=1 at a rising edge: state=IDLE, ftdi_oe_n=1, ftdi_rd_n=1, buffer emptied, host_axis_tvalid=0, rx_byte_count=0.
REQ-034 Reset asserted mid-READ SHALL deassert both strobes at that edge; bytes in the buffer or on the bus SHALL be discarded.
REQ-035 The first edge after rst falls SHALL evaluate IDLE transitions normally.

Verification
REQ-036 Bench: rxf_n low with bytes 0x11,0x22,0x33 then high, tready=1 -> oe_n low 1 cycle before rd_n; exactly 3 bytes out in order; rx_byte_count=3; both strobes high after rxf_n rises.
REQ-037 Bench: tready=0, rxf_n held low, SKID_DEPTH=4 -> rd_n rises once count reaches 2 or 3; count never exceeds 4; with tready=1, all bytes drain in order, then reading resumes.
REQ-038 Bench: rxf_n low for one cycle only, during TURNAROUND -> no capture; return to IDLE; tvalid stays 0.
REQ-039 Bench: continuous 256-byte burst with random tready -> output equals input sequence; no gaps or duplicates; rx_byte_count=256.
REQ-040 Bench: rst pulsed during READ with 2 bytes buffered -> strobes high next edge; tvalid=0; rx_byte_count=0; next burst 0xA5 delivered correctly.
REQ-041 Bench: rx_byte_count preloaded near 0xFFFFFFFF via forced stimulus, then 2 pops -> count wraps to 0x00000000 then 0x00000001.
